// File: rtl/gsram_arbiter.sv
// -----------------------------------------------------------------------------
// gsram_arbiter
//   Shares one single-port ROWS x COLS x DW grid SRAM between two requesters
//   (A and B) using round-robin arbitration with a valid/ready handshake.
//   Reads return data one cycle after acceptance with a one-cycle response
//   strobe to the requester that issued them. A clear engine zeroes the whole
//   grid, one cell per cycle in row-major order, when clr_start is pulsed.
//
// Ports
//   clk, rst_n              clock (posedge), synchronous active-low reset
//   clr_start / clr_busy    clear command pulse / clear in progress
//   x_req_valid/x_req_ready request handshake (x = a, b); ready is combinational
//   x_we, x_row, x_col      request type (1=write) and grid address
//   x_wdata                 write data
//   x_rsp_valid, x_rdata    read response strobe and data (cycle after accept)
//   oob_err                 accepted request addressed outside the grid
//   sram_we/row/col/wdata   SRAM command port
//   sram_rdata              SRAM registered read data
// -----------------------------------------------------------------------------
module gsram_arbiter #(
    parameter int ROWS = 10,
    parameter int COLS = 10,
    parameter int AW   = 4,
    parameter int DW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_start,
    output logic          clr_busy,
    input  logic          a_req_valid,
    output logic          a_req_ready,
    input  logic          a_we,
    input  logic [AW-1:0] a_row,
    input  logic [AW-1:0] a_col,
    input  logic [DW-1:0] a_wdata,
    output logic          a_rsp_valid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req_valid,
    output logic          b_req_ready,
    input  logic          b_we,
    input  logic [AW-1:0] b_row,
    input  logic [AW-1:0] b_col,
    input  logic [DW-1:0] b_wdata,
    output logic          b_rsp_valid,
    output logic [DW-1:0] b_rdata,
    output logic          oob_err,
    output logic          sram_we,
    output logic [AW-1:0] sram_row,
    output logic [AW-1:0] sram_col,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
);

    typedef enum logic {IDLE, CLEAR} state_t;

    // One extra bit so the bounds still compare correctly if ROWS/COLS == 2**AW.
    localparam logic [AW:0]   ROWS_W   = (AW+1)'(ROWS);
    localparam logic [AW:0]   COLS_W   = (AW+1)'(COLS);
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
    localparam logic [AW-1:0] LAST_COL = AW'(COLS - 1);

    state_t        state;
    logic [AW-1:0] clr_row;
    logic [AW-1:0] clr_col;
    logic          prefer_b;     // 1 when A was granted last, so B wins a tie
    logic          rsp_a;
    logic          rsp_b;
    logic          rsp_zero;     // pending response came from an out-of-range read
    logic [AW-1:0] hold_row;
    logic [AW-1:0] hold_col;

    logic          arb_en;
    logic          grant_a;
    logic          grant_b;
    logic          grant;
    logic          g_we;
    logic [AW-1:0] g_row;
    logic [AW-1:0] g_col;
    logic [DW-1:0] g_wdata;
    logic          g_oob;

    // Arbitration: a pending clr_start blocks grants in the same cycle.
    always_comb begin
        arb_en  = rst_n && (state == IDLE) && !clr_start;
        grant_a = arb_en && a_req_valid && (!b_req_valid || !prefer_b);
        grant_b = arb_en && b_req_valid && (!a_req_valid ||  prefer_b);
        grant   = grant_a || grant_b;

        g_we    = grant_b ? b_we    : a_we;
        g_row   = grant_b ? b_row   : a_row;
        g_col   = grant_b ? b_col   : a_col;
        g_wdata = grant_b ? b_wdata : a_wdata;
        g_oob   = grant && (({1'b0, g_row} >= ROWS_W) || ({1'b0, g_col} >= COLS_W));
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;
    assign oob_err     = g_oob;

    // SRAM command mux. Without a grant the address is held so idle cycles
    // only re-read the last cell; out-of-range requests go to (0,0) with the
    // write suppressed.
    always_comb begin
        sram_we    = 1'b0;
        sram_row   = hold_row;
        sram_col   = hold_col;
        sram_wdata = '0;
        if (state == CLEAR) begin
            sram_we  = rst_n;
            sram_row = clr_row;
            sram_col = clr_col;
        end else if (grant) begin
            sram_we    = g_we && !g_oob;
            sram_row   = g_oob ? '0 : g_row;
            sram_col   = g_oob ? '0 : g_col;
            sram_wdata = g_wdata;
        end
    end

    // Responses are steered only to the requester that issued the read.
    assign a_rsp_valid = rsp_a;
    assign b_rsp_valid = rsp_b;
    assign a_rdata     = (rsp_a && !rsp_zero) ? sram_rdata : '0;
    assign b_rdata     = (rsp_b && !rsp_zero) ? sram_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            clr_row  <= '0;
            clr_col  <= '0;
            clr_busy <= 1'b0;
            prefer_b <= 1'b0;
            rsp_a    <= 1'b0;
            rsp_b    <= 1'b0;
            rsp_zero <= 1'b0;
            hold_row <= '0;
            hold_col <= '0;
        end else begin
            rsp_a    <= grant_a && !a_we;
            rsp_b    <= grant_b && !b_we;
            rsp_zero <= g_oob;
            hold_row <= sram_row;
            hold_col <= sram_col;
            if (grant) begin
                prefer_b <= grant_a;
            end
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state    <= CLEAR;
                        clr_busy <= 1'b1;
                        clr_row  <= '0;
                        clr_col  <= '0;
                    end
                end
                CLEAR: begin
                    // clr_start is ignored here; the sweep always runs to completion.
                    if (clr_col == LAST_COL) begin
                        clr_col <= '0;
                        if (clr_row == LAST_ROW) begin
                            state    <= IDLE;
                            clr_busy <= 1'b0;
                        end else begin
                            clr_row <= clr_row + 1'b1;
                        end
                    end else begin
                        clr_col <= clr_col + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gsram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gsram_arbiter
//   Bench for gsram_arbiter: a behavioural SRAM, a grid-level reference model
//   checked every cycle on the falling edge, and directed scenarios with
//   hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_gsram_arbiter;

    localparam int ROWS = 10;
    localparam int COLS = 10;
    localparam int AW   = 4;
    localparam int DW   = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr_start;
    logic          clr_busy;
    logic          a_req_valid, a_req_ready, a_we, a_rsp_valid;
    logic [AW-1:0] a_row, a_col;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req_valid, b_req_ready, b_we, b_rsp_valid;
    logic [AW-1:0] b_row, b_col;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          oob_err;
    logic          sram_we;
    logic [AW-1:0] sram_row, sram_col;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gsram_arbiter #(.ROWS(ROWS), .COLS(COLS), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .clr_busy(clr_busy),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_we(a_we),
        .a_row(a_row), .a_col(a_col), .a_wdata(a_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_we(b_we),
        .b_row(b_row), .b_col(b_col), .b_wdata(b_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rdata(b_rdata),
        .oob_err(oob_err), .sram_we(sram_we), .sram_row(sram_row),
        .sram_col(sram_col), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Single-port SRAM with registered read data (full 4-bit address space).
    logic [DW-1:0] mem [16][16];
    always @(posedge clk) begin
        if (sram_we) mem[sram_row][sram_col] <= sram_wdata;
        sram_rdata <= mem[sram_row][sram_col];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            live = 0;
    int            m_clear_left = 0;   // clear cells still to write
    bit            m_last_a = 0;       // A received the most recent grant
    bit            m_pa = 0, m_pb = 0; // read response owed next cycle
    logic [DW-1:0] m_pdata = '0;
    logic [DW-1:0] m_grid [ROWS][COLS];

    always @(negedge clk) begin
        bit            ea, eb, w, oob;
        int            r, c, idx;
        logic [DW-1:0] wd;
        if (live) begin
            chk("a_rsp_valid", a_rsp_valid, m_pa);
            chk("b_rsp_valid", b_rsp_valid, m_pb);
            if (m_pa) chk("a_rdata", a_rdata, m_pdata);
            if (m_pb) chk("b_rdata", b_rdata, m_pdata);
            chk("clr_busy", clr_busy, m_clear_left > 0);

            ea = 0; eb = 0;
            if (rst_n && m_clear_left == 0 && !clr_start) begin
                if (a_req_valid && b_req_valid) begin
                    ea = !m_last_a; eb = m_last_a;
                end else begin
                    ea = a_req_valid; eb = b_req_valid;
                end
            end
            chk("a_req_ready", a_req_ready, ea);
            chk("b_req_ready", b_req_ready, eb);

            w   = ea ? a_we : b_we;
            r   = ea ? int'(a_row) : int'(b_row);
            c   = ea ? int'(a_col) : int'(b_col);
            wd  = ea ? a_wdata : b_wdata;
            oob = (ea || eb) && (r >= ROWS || c >= COLS);
            chk("oob_err", oob_err, oob);

            idx = ROWS * COLS - m_clear_left;
            if (rst_n && m_clear_left > 0) begin
                chk("clr_we", sram_we, 1);
                chk("clr_row", sram_row, idx / COLS);
                chk("clr_col", sram_col, idx % COLS);
                chk("clr_wdata", sram_wdata, 0);
            end else if (ea || eb) begin
                chk("sram_we", sram_we, w && !oob);
                if (!oob) begin
                    chk("sram_row", sram_row, r);
                    chk("sram_col", sram_col, c);
                    if (w) chk("sram_wdata", sram_wdata, wd);
                end else if (!w) begin
                    chk("oob_row", sram_row, 0);
                    chk("oob_col", sram_col, 0);
                end
            end else begin
                chk("sram_we_idle", sram_we, 0);
            end

            // advance the model across the coming rising edge
            m_pa = 0; m_pb = 0;
            if (!rst_n) begin
                m_clear_left = 0;
                m_last_a     = 0;
            end else if (m_clear_left > 0) begin
                m_grid[idx / COLS][idx % COLS] = '0;
                m_clear_left--;
            end else if (clr_start) begin
                m_clear_left = ROWS * COLS;
            end else if (ea || eb) begin
                m_last_a = ea;
                if (!w) begin
                    m_pa = ea; m_pb = eb;
                    m_pdata = oob ? '0 : m_grid[r][c];
                end else if (!oob) begin
                    m_grid[r][c] = wd;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_a(input bit v, input bit we, input int r, input int c, input logic [DW-1:0] d);
        a_req_valid = v; a_we = we; a_row = AW'(r); a_col = AW'(c); a_wdata = d;
    endtask

    task automatic set_b(input bit v, input bit we, input int r, input int c, input logic [DW-1:0] d);
        b_req_valid = v; b_we = we; b_row = AW'(r); b_col = AW'(c); b_wdata = d;
    endtask

    task automatic fill_ffff();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                set_a(1, 1, r, c, 16'hFFFF);
                tick();
            end
        set_a(0, 0, 0, 0, '0);
    endtask

    initial begin
        logic [3:0] pat_a, pat_b;
        int         busy, nz, nf;
        bit         done;

        rst_n = 0; clr_start = 0;
        set_a(1, 0, 0, 0, '0);
        set_b(1, 0, 0, 0, '0);
        #1;
        chk("rst_a_ready", a_req_ready, 0);
        chk("rst_b_ready", b_req_ready, 0);
        chk("rst_sram_we", sram_we, 0);
        tick(); tick();
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_a_rsp", a_rsp_valid, 0);
        live = 1; rst_n = 1;
        set_a(0, 0, 0, 0, '0);
        set_b(0, 0, 0, 0, '0);

        // write then read back from A
        set_a(1, 1, 3, 4, 16'hBEEF); #1;
        chk("wr_a_ready", a_req_ready, 1);
        tick();
        set_a(1, 0, 3, 4, '0);
        tick();
        set_a(0, 0, 0, 0, '0); #1;
        chk("rd_a_valid", a_rsp_valid, 1);
        chk("rd_a_data", a_rdata, 16'hBEEF);
        chk("rd_b_quiet", b_rsp_valid, 0);

        // B write, then both requesters contend for 4 cycles
        set_b(1, 1, 2, 2, 16'h2222);
        tick();
        set_a(1, 0, 3, 4, '0);
        set_b(1, 0, 2, 2, '0);
        for (int i = 0; i < 4; i++) begin
            #1;
            pat_a[i] = a_req_ready;
            pat_b[i] = b_req_ready;
            tick();
        end
        set_a(0, 0, 0, 0, '0);
        set_b(0, 0, 0, 0, '0); #1;
        chk("rr_pattern_a", pat_a, 4'b0101);
        chk("rr_pattern_b", pat_b, 4'b1010);
        chk("rr_last_b_rsp", b_rsp_valid, 1);
        chk("rr_last_b_data", b_rdata, 16'h2222);

        // out-of-range accesses
        set_a(1, 1, 0, 0, 16'hAAAA);
        tick();
        set_a(0, 0, 0, 0, '0);
        set_b(1, 1, 12, 0, 16'h1234); #1;
        chk("oob_wr_ready", b_req_ready, 1);
        chk("oob_wr_err", oob_err, 1);
        chk("oob_wr_we", sram_we, 0);
        tick();
        set_b(1, 0, 9, 15, '0); #1;
        chk("oob_rd_err", oob_err, 1);
        tick();
        set_b(0, 0, 0, 0, '0); #1;
        chk("oob_rd_valid", b_rsp_valid, 1);
        chk("oob_rd_data", b_rdata, 0);

        // full clear with A waiting; clr_start repeated mid-clear
        fill_ffff();
        set_a(1, 0, 5, 5, '0);
        tick();
        set_a(1, 0, 0, 0, '0);
        clr_start = 1; #1;
        chk("clr_start_block", a_req_ready, 0);
        tick();
        clr_start = 0;
        busy = 0; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (clr_busy) begin
                busy++;
                clr_start = (busy == 40);
                tick();
            end else begin
                done = 1;
            end
        end
        clr_start = 0; #1;
        chk("clr_busy_cycles", busy, 100);
        chk("post_clr_grant", a_req_ready, 1);
        tick();
        set_a(1, 0, 9, 9, '0); #1;
        chk("clr_rd00_valid", a_rsp_valid, 1);
        chk("clr_rd00_data", a_rdata, 0);
        tick();
        set_a(0, 0, 0, 0, '0); #1;
        chk("clr_rd99_data", a_rdata, 0);
        nz = 0;
        for (int k = 0; k < ROWS * COLS; k++)
            if (mem[k / COLS][k % COLS] == 16'h0000) nz++;
        chk("clr_zero_cells", nz, 100);

        // reset in clear cycle 50 aborts the sweep
        fill_ffff();
        clr_start = 1;
        tick();
        clr_start = 0;
        repeat (50) tick();
        chk("abort_busy_before", clr_busy, 1);
        rst_n = 0;
        tick();
        rst_n = 1; #1;
        chk("abort_busy_after", clr_busy, 0);
        nz = 0; nf = 0;
        for (int k = 0; k < ROWS * COLS; k++) begin
            if (k < 50 && mem[k / COLS][k % COLS] == 16'h0000) nz++;
            if (k >= 50 && mem[k / COLS][k % COLS] == 16'hFFFF) nf++;
        end
        chk("abort_zeroed", nz, 50);
        chk("abort_kept", nf, 50);
        set_b(1, 0, 5, 0, '0);
        tick();
        set_b(0, 0, 0, 0, '0); #1;
        chk("abort_rd50", b_rdata, 16'hFFFF);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
